// File: rtl/sobel_win_ctrl.sv
// sobel_win_ctrl: streams a raster image through two line buffers and a 3x3
// window, hands each window to an external sobel datapath with one cycle of
// latency and returns one gradient per pixel in raster order, with border
// pixels forced to zero.
module sobel_win_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [8:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] s_din0,
    output logic [7:0] s_din1,
    output logic [7:0] s_din2,
    output logic [7:0] s_din3,
    output logic [7:0] s_din4,
    output logic [7:0] s_din5,
    output logic [7:0] s_din6,
    output logic [7:0] s_din7,
    output logic [7:0] s_din8,
    input  logic [8:0] s_dout
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state;

    // input position of the pixel currently offered, and position of the next
    // output to enter the pipeline
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;

    // stage 1 owns the window currently on s_din*; the output stage owns out_*
    logic       s1_valid;
    logic       s1_border;
    logic       s1_last;
    logic       out_border;
    logic       out_last;
    logic       all_loaded;

    // once the output stalls, s_dout moves on to the next window, so the
    // result belonging to the stalled output is parked here
    logic       held;
    logic [8:0] dout_hold;

    logic [7:0] lb_top [IMG_W];
    logic [7:0] lb_mid [IMG_W];

    logic adv;
    logic accept;
    logic primed;
    logic load;
    logic out_fire;
    logic pos_border;
    logic pos_last;

    assign adv        = out_ready || !out_valid;
    assign in_ready   = (state == RUN) && adv;
    assign accept     = in_ready && in_valid;
    assign primed     = (in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0));
    assign load       = (accept && primed) || ((state == FLUSH) && adv && !all_loaded);
    assign out_fire   = out_valid && out_ready;
    assign pos_border = (out_row == '0) || (out_row == ROW_LAST) ||
                        (out_col == '0) || (out_col == COL_LAST);
    assign pos_last   = (out_row == ROW_LAST) && (out_col == COL_LAST);
    assign out_data   = (out_valid && !out_border) ? (held ? dout_hold : s_dout) : '0;

    // frame sequencing, position counters and the two-stage output pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            s1_valid   <= 1'b0;
            s1_border  <= 1'b0;
            s1_last    <= 1'b0;
            out_valid  <= 1'b0;
            out_border <= 1'b0;
            out_last   <= 1'b0;
            all_loaded <= 1'b0;
            held       <= 1'b0;
            dout_hold  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        all_loaded <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && (in_col == COL_LAST) && (in_row == ROW_LAST)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_fire && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            if (load) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
                if (pos_last) begin
                    all_loaded <= 1'b1;
                end
            end

            if (adv) begin
                out_valid  <= s1_valid;
                out_border <= s1_border;
                out_last   <= s1_last;
                s1_valid   <= load;
                s1_border  <= pos_border;
                s1_last    <= pos_last;
                held       <= 1'b0;
            end else if (!held) begin
                held      <= 1'b1;
                dout_hold <= s_dout;
            end
        end
    end

    // 3x3 window shifts left by one column on every accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_din0 <= '0;
            s_din1 <= '0;
            s_din2 <= '0;
            s_din3 <= '0;
            s_din4 <= '0;
            s_din5 <= '0;
            s_din6 <= '0;
            s_din7 <= '0;
            s_din8 <= '0;
        end else if (accept) begin
            s_din0 <= s_din1;
            s_din1 <= s_din2;
            s_din2 <= lb_top[in_col];
            s_din3 <= s_din4;
            s_din4 <= s_din5;
            s_din5 <= lb_mid[in_col];
            s_din6 <= s_din7;
            s_din7 <= s_din8;
            s_din8 <= in_data;
        end
    end

    // line buffers hold the two previous rows; contents survive reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[in_col] <= lb_mid[in_col];
            lb_mid[in_col] <= in_data;
        end
    end

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// tb_sobel_win_ctrl: directed frames on a 4x4 image against a behavioural
// sobel datapath with one cycle of latency.
module tb_sobel_win_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] s_din0, s_din1, s_din2, s_din3, s_din4, s_din5, s_din6, s_din7, s_din8;
    logic [8:0] s_dout = 9'd0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nOut = 0;
    int nDone = 0;
    int lastHsCycle = 0;
    int doneCycle = 0;
    int readyViol = 0;
    int holdViol = 0;
    int busyDrops = 0;
    bit randReady = 1'b0;
    logic       prevStall = 1'b0;
    logic [8:0] prevData = 9'd0;
    logic [8:0] obs [256];

    int expConst [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int expRamp  [16] = '{0, 0, 0, 0, 0, 80, 80, 0, 0, 80, 80, 0, 0, 0, 0, 0};

    sobel_win_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .s_din0(s_din0), .s_din1(s_din1), .s_din2(s_din2),
        .s_din3(s_din3), .s_din4(s_din4), .s_din5(s_din5),
        .s_din6(s_din6), .s_din7(s_din7), .s_din8(s_din8),
        .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    // |gx| + |gy|, saturated to 9 bits
    function automatic logic [8:0] sobelModel(input logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8);
        int gx, gy, m;
        gx = (int'(p2) + 2 * int'(p5) + int'(p8)) - (int'(p0) + 2 * int'(p3) + int'(p6));
        gy = (int'(p6) + 2 * int'(p7) + int'(p8)) - (int'(p0) + 2 * int'(p1) + int'(p2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 511) m = 511;
        return 9'(m);
    endfunction

    always @(posedge clk) s_dout <= sobelModel(s_din0, s_din1, s_din2, s_din3, s_din5, s_din6, s_din7, s_din8);

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // mid-cycle observer of handshakes, done pulses and stall behaviour
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prevStall && (!out_valid || out_data !== prevData)) holdViol++;
            if (in_ready && out_valid && !out_ready) readyViol++;
            if (out_valid && out_ready) begin
                if (nOut < 256) obs[nOut] = out_data;
                nOut++;
                lastHsCycle = cyc;
            end
            if (done) begin
                nDone++;
                doneCycle = cyc;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic startFrame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 1);
    endtask

    task automatic applyStimulus(input int kind, input int gapMax, input int count, input int pokeAt);
        bit acc;
        int guard;
        for (int i = 0; i < count; i++) begin
            if (gapMax > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, gapMax)) begin
                    @(posedge clk);
                    #1;
                    if (!busy) busyDrops++;
                end
            end
            in_valid = 1'b1;
            in_data  = (kind == 1) ? 8'(10 * (i % W)) : 8'd100;
            if (i == pokeAt) start = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                guard++;
                if (!busy) busyDrops++;
            end
            if (!acc) checkOutput("in_accept_timeout", 0, 1);
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
    endtask

    task automatic waitDone(output bit got);
        int guard;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 400) begin
            @(posedge clk);
            #1;
            got = done;
            guard++;
            if (!got && !busy) busyDrops++;
        end
    endtask

    task automatic frameChecks(input string label, input int expv [16], input int bo, input int bd);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput({label, "_count"}, 32'(nOut - bo), N);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_px%0d", label, i), 32'(obs[bo + i]), 32'(expv[i]));
        end
        checkOutput({label, "_done_count"}, 32'(nDone - bd), 1);
        checkOutput({label, "_done_latency"}, 32'(doneCycle - lastHsCycle), 1);
        checkOutput({label, "_busy_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int bo;
        int bd;
        bit got;

        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_s_din0", 32'(s_din0), 0);
        checkOutput("rst_s_din8", 32'(s_din8), 0);

        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 0);
        checkOutput("idle_busy", 32'(busy), 0);

        // constant image, output always ready
        bo = nOut; bd = nDone;
        startFrame();
        applyStimulus(0, 0, N, -1);
        waitDone(got);
        checkOutput("const_done_seen", 32'(got), 1);
        frameChecks("const", expConst, bo, bd);

        // horizontal ramp
        bo = nOut; bd = nDone;
        startFrame();
        applyStimulus(1, 0, N, -1);
        waitDone(got);
        checkOutput("ramp_done_seen", 32'(got), 1);
        frameChecks("ramp", expRamp, bo, bd);

        // ramp with output backpressure
        randReady = 1'b1;
        readyViol = 0;
        holdViol = 0;
        bo = nOut; bd = nDone;
        startFrame();
        applyStimulus(1, 0, N, -1);
        waitDone(got);
        randReady = 1'b0;
        checkOutput("bp_done_seen", 32'(got), 1);
        frameChecks("bp", expRamp, bo, bd);
        checkOutput("bp_ready_guard", 32'(readyViol), 0);
        checkOutput("bp_hold_stable", 32'(holdViol), 0);

        // ramp with input gaps
        busyDrops = 0;
        bo = nOut; bd = nDone;
        startFrame();
        applyStimulus(1, 5, N, -1);
        waitDone(got);
        checkOutput("gap_done_seen", 32'(got), 1);
        checkOutput("gap_busy_held", 32'(busyDrops), 0);
        frameChecks("gap", expRamp, bo, bd);

        // abort mid-frame with reset, then a fresh frame
        bd = nDone;
        startFrame();
        applyStimulus(0, 0, 7, -1);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        checkOutput("abort_s_din8", 32'(s_din8), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bo = nOut;
        startFrame();
        checkOutput("abort_no_done", 32'(nDone - bd), 0);
        bd = nDone;
        applyStimulus(0, 0, N, -1);
        waitDone(got);
        checkOutput("after_abort_done_seen", 32'(got), 1);
        frameChecks("after_abort", expConst, bo, bd);

        // start while busy and start held through the done cycle
        bo = nOut; bd = nDone;
        startFrame();
        applyStimulus(1, 0, N, 8);
        start = 1'b1;
        waitDone(got);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("dup_done_seen", 32'(got), 1);
        frameChecks("dup_start", expRamp, bo, bd);
        checkOutput("dup_in_ready", 32'(in_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_win_ctrl.md
SOBEL_WIN_CTRL -- requirements
Module: sobel_win_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per row (minimum 3).
REQ-002 SHALL have parameter IMG_H, default 480, meaning rows per frame (minimum 3).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame start pulse, honoured only in IDLE.
REQ-006 SHALL have port busy  output  1  high from the accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last output handshake of a frame.
REQ-008 SHALL have ports in_data/in_valid/in_ready  input 8/input 1/output 1  raster pixel stream, transfer when in_valid&&in_ready.
REQ-009 SHALL have ports out_data/out_valid/out_ready  output 9/output 1/input 1  raster gradient stream, transfer when out_valid&&out_ready.
REQ-010 SHALL have ports s_din0..s_din8  output  8 each  3x3 window to the sobel datapath, din0..din2 top row left-to-right, din3..din5 middle, din6..din8 bottom.
REQ-011 SHALL have port s_dout  input  9  sobel result, valid exactly one clk after its window is presented.

Function
REQ-012 SHALL implement FSM IDLE -> RUN (start) -> FLUSH (IMG_W*IMG_H inputs accepted) -> IDLE (last output accepted, done pulses).
REQ-013 SHALL hold in_ready low in IDLE and FLUSH; in RUN in_ready SHALL equal pipeline advance (out_ready || !out_valid).
REQ-014 SHALL store the two most recent rows in two IMG_W x 8 line buffers plus a 3x3 shift window; column and row counters SHALL wrap at IMG_W-1 and IMG_H-1.
REQ-015 SHALL emit exactly IMG_W*IMG_H outputs per frame in raster order; output index k=r*IMG_W+c is issued after input index k+IMG_W+1 is accepted, or in FLUSH for indices with no such input.
REQ-016 SHALL output 0 for border pixels (r=0, r=IMG_H-1, c=0, c=IMG_W-1) without consulting s_dout; interior pixels SHALL output s_dout zero-extended unchanged.
REQ-017 SHALL present the window for interior pixel (r,c) on s_din* one cycle before out_valid for that pixel, holding s_din* stable while stalled.
REQ-018 SHALL hold out_data and out_valid stable while out_valid&&!out_ready; no output SHALL be dropped or duplicated.
REQ-019 In FLUSH, outputs SHALL be issued at one per cycle when out_ready is high.
REQ-020 start while busy SHALL be ignored; start and done in the same cycle SHALL not begin a new frame (start must be re-issued in IDLE).
REQ-021 in_data presented while in_ready is low SHALL be ignored.

Reset
REQ-022 While rst_n low: state=IDLE, counters=0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, s_din0..8=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse; line-buffer contents need not be cleared.
REQ-024 After rst_n deasserts, the block SHALL accept start on the first clk edge.

Verification (IMG_W=4, IMG_H=4, behavioural sobel model with 1-cycle latency)
REQ-025 Constant 100 image, out_ready=1 -> 16 outputs, all 0 (borders 0, interior gradient 0), done one cycle after 16th output.
REQ-026 Horizontal ramp pixel=10*c -> interior outputs (1,1),(1,2),(2,1),(2,2) equal the sobel model for ramp (t1=80, t2=0 -> model value), all borders 0.
REQ-027 out_ready toggled pseudo-randomly 50% -> output sequence identical to REQ-026, in_ready never high while out_valid&&!out_ready.
REQ-028 in_valid gaps of 1-5 cycles -> same 16-value sequence, no extra outputs, busy high throughout.
REQ-029 rst_n pulsed low after 7 inputs, then new start with constant-100 frame -> no done for aborted frame, second frame per REQ-025.
REQ-030 start pulsed during busy and coincident with done -> ignored, exactly one done per real frame.
